// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the output-stationary MAC processing element.
package pe_pkg;

   localparam int unsigned SAT_W = 64;

   typedef enum logic [0:0] {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_e;

   function automatic int unsigned acc_width_default(input int unsigned width);
      return (32'd2 * width) + 32'd8;
   endfunction

   // Adds two acc_w-bit values held in the low bits of SAT_W-bit words (acc_w <= SAT_W).
   function automatic logic [SAT_W-1:0] sat_add(
      input logic [SAT_W-1:0] a,
      input logic [SAT_W-1:0] b,
      input int unsigned      acc_w,
      input logic             is_signed,
      input logic             saturate
   );
      logic [SAT_W-1:0] mask_v;
      logic [SAT_W-1:0] smax_v;
      logic [SAT_W-1:0] smin_v;
      logic [SAT_W-1:0] sum_v;
      logic [SAT_W-1:0] res_v;
      logic [SAT_W:0]   wide_v;
      logic [SAT_W:0]   carry_v;
      logic             sa_v;
      logic             sb_v;
      logic             ss_v;
      mask_v  = (64'd1 << acc_w) - 64'd1;
      smax_v  = mask_v >> 1;
      smin_v  = mask_v & ~smax_v;
      wide_v  = {1'b0, a & mask_v} + {1'b0, b & mask_v};
      sum_v   = wide_v[SAT_W-1:0] & mask_v;
      carry_v = wide_v >> acc_w;
      sa_v    = |(a & smin_v);
      sb_v    = |(b & smin_v);
      ss_v    = |(sum_v & smin_v);
      if (!saturate) begin
         res_v = sum_v;
      end else if (!is_signed) begin
         res_v = carry_v[0] ? mask_v : sum_v;
      end else if ((sa_v == sb_v) && (ss_v != sa_v)) begin
         res_v = sa_v ? smin_v : smax_v;
      end else begin
         res_v = sum_v;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/pe_drain_slot.sv
// Drain output register for one PE: local result first, otherwise pass upstream data down the column.
module pe_drain_slot #(
   parameter int unsigned ACC_WIDTH = 24
) (
   input  logic                 CLK,
   input  logic                 SYNC_RST,
   input  logic [ACC_WIDTH-1:0] res,
   input  logic                 res_full,
   output logic                 res_take,
   input  logic [ACC_WIDTH-1:0] psum_in,
   input  logic                 psum_in_valid,
   output logic                 psum_in_ready,
   output logic [ACC_WIDTH-1:0] psum_out,
   output logic                 psum_out_valid,
   input  logic                 psum_out_ready
);

   logic [ACC_WIDTH-1:0] out_data_r;
   logic                 out_valid_r;
   logic                 load_ok_s;

   // Slot can reload when empty or when its content leaves this cycle.
   always_comb begin
      load_ok_s     = !out_valid_r || psum_out_ready;
      res_take      = load_ok_s && res_full;
      psum_in_ready = load_ok_s && !res_full;
   end

   // Output register with local-first source selection.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         out_data_r  <= {ACC_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else if (res_take) begin
         out_data_r  <= res;
         out_valid_r <= 1'b1;
      end else if (psum_in_ready && psum_in_valid) begin
         out_data_r  <= psum_in;
         out_valid_r <= 1'b1;
      end else if (load_ok_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign psum_out       = out_data_r;
   assign psum_out_valid = out_valid_r;

endmodule

// File: rtl/os_mac_pe.sv
// Output-stationary MAC PE: forwards operands, accumulates a K-length tile, buffers and drains results.
module os_mac_pe
   import pe_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = acc_width_default(WIDTH),
   parameter logic        SIGNED    = 1'b0,
   parameter logic        SATURATE  = 1'b1
) (
   input  logic                 CLK,
   input  logic                 SYNC_RST,
   input  logic                 EN,
   input  logic                 InValid,
   input  logic                 InLast,
   input  logic [WIDTH-1:0]     Input,
   input  logic [WIDTH-1:0]     Weight,
   output logic [WIDTH-1:0]     ToRight,
   output logic                 ToRightValid,
   output logic                 ToRightLast,
   output logic [WIDTH-1:0]     ToDown,
   input  logic [ACC_WIDTH-1:0] PsumIn,
   input  logic                 PsumInValid,
   output logic                 PsumInReady,
   output logic [ACC_WIDTH-1:0] PsumOut,
   output logic                 PsumOutValid,
   input  logic                 PsumOutReady,
   output logic                 Overrun
);

   acc_state_e           state_r;
   acc_state_e           state_nx_s;
   logic [ACC_WIDTH-1:0] acc_r;
   logic [ACC_WIDTH-1:0] res_r;
   logic                 res_full_r;
   logic                 overrun_r;
   logic [ACC_WIDTH-1:0] a_ext_s;
   logic [ACC_WIDTH-1:0] w_ext_s;
   logic [ACC_WIDTH-1:0] prod_s;
   logic [ACC_WIDTH-1:0] base_s;
   logic [ACC_WIDTH-1:0] acc_sum_s;
   logic                 step_s;
   logic                 finish_s;
   logic                 res_take_s;
   logic [WIDTH-1:0]     to_right_r;
   logic [WIDTH-1:0]     to_down_r;
   logic                 to_right_valid_r;
   logic                 to_right_last_r;

   // Operand extension, product and saturating accumulate; low ACC_WIDTH bits of the
   // extended product equal the exact product since ACC_WIDTH >= 2*WIDTH.
   always_comb begin
      step_s   = EN && InValid;
      finish_s = step_s && InLast;
      if (SIGNED) begin
         a_ext_s = ACC_WIDTH'($signed(Input));
         w_ext_s = ACC_WIDTH'($signed(Weight));
      end else begin
         a_ext_s = ACC_WIDTH'(Input);
         w_ext_s = ACC_WIDTH'(Weight);
      end
      prod_s    = a_ext_s * w_ext_s;
      base_s    = (state_r == ACC_RUN) ? acc_r : {ACC_WIDTH{1'b0}};
      acc_sum_s = ACC_WIDTH'(sat_add(SAT_W'(base_s), SAT_W'(prod_s), ACC_WIDTH, SIGNED, SATURATE));
   end

   // Accumulator FSM next state.
   always_comb begin
      state_nx_s = state_r;
      if (step_s) begin
         state_nx_s = InLast ? ACC_IDLE : ACC_RUN;
      end else begin
         state_nx_s = state_r;
      end
   end

   // Accumulator FSM state register.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         state_r <= ACC_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Accumulator, result buffer and sticky overrun flag.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         acc_r      <= {ACC_WIDTH{1'b0}};
         res_r      <= {ACC_WIDTH{1'b0}};
         res_full_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         if (step_s) begin
            acc_r <= InLast ? {ACC_WIDTH{1'b0}} : acc_sum_s;
         end
         if (finish_s) begin
            res_r      <= acc_sum_s;
            res_full_r <= 1'b1;
         end else if (res_take_s) begin
            res_full_r <= 1'b0;
         end
         // A new result landing on an undrained one loses the old one.
         if (finish_s && res_full_r && !res_take_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   // Operand forwarding to the neighbouring PEs.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         to_right_r       <= {WIDTH{1'b0}};
         to_down_r        <= {WIDTH{1'b0}};
         to_right_valid_r <= 1'b0;
         to_right_last_r  <= 1'b0;
      end else if (EN) begin
         to_right_r       <= Input;
         to_down_r        <= Weight;
         to_right_valid_r <= InValid;
         to_right_last_r  <= InLast;
      end else begin
         to_right_r       <= to_right_r;
         to_down_r        <= to_down_r;
         to_right_valid_r <= to_right_valid_r;
         to_right_last_r  <= to_right_last_r;
      end
   end

   pe_drain_slot #(
      .ACC_WIDTH(ACC_WIDTH)
   ) u_drain (
      .CLK           (CLK),
      .SYNC_RST      (SYNC_RST),
      .res           (res_r),
      .res_full      (res_full_r),
      .res_take      (res_take_s),
      .psum_in       (PsumIn),
      .psum_in_valid (PsumInValid),
      .psum_in_ready (PsumInReady),
      .psum_out      (PsumOut),
      .psum_out_valid(PsumOutValid),
      .psum_out_ready(PsumOutReady)
   );

   assign ToRight      = to_right_r;
   assign ToDown       = to_down_r;
   assign ToRightValid = to_right_valid_r;
   assign ToRightLast  = to_right_last_r;
   assign Overrun      = overrun_r;

endmodule

// File: tb/tb_os_mac_pe.sv
// Scoreboard bench for os_mac_pe: three parameterisations share one stimulus stream.
module tb_os_mac_pe;

   logic        clk = 1'b0;
   logic        sync_rst;
   logic        en, in_valid, in_last, out_ready, psum_in_valid;
   logic [7:0]  act, wgt;
   logic [23:0] psum_in;

   logic [7:0]  to_right[3];
   logic [7:0]  to_down[3];
   logic        trv[3];
   logic        trl[3];
   logic        pir[3];
   logic        pov[3];
   logic        ovr[3];
   logic [23:0] po0;
   logic [15:0] po1, po2;
   logic [23:0] po_w[3];

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] exq[3][$];
   logic [7:0]  ta[8];
   logic [7:0]  tb[8];
   logic [17:0] fwd_exp;
   bit          fwd_known = 1'b0;
   bit          hold_v[3];
   logic [23:0] hold_d[3];

   always #5 clk = ~clk;

   os_mac_pe u0 (
      .CLK(clk), .SYNC_RST(sync_rst), .EN(en), .InValid(in_valid), .InLast(in_last),
      .Input(act), .Weight(wgt), .ToRight(to_right[0]), .ToRightValid(trv[0]),
      .ToRightLast(trl[0]), .ToDown(to_down[0]), .PsumIn(psum_in), .PsumInValid(psum_in_valid),
      .PsumInReady(pir[0]), .PsumOut(po0), .PsumOutValid(pov[0]), .PsumOutReady(out_ready),
      .Overrun(ovr[0]));

   os_mac_pe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) u1 (
      .CLK(clk), .SYNC_RST(sync_rst), .EN(en), .InValid(in_valid), .InLast(in_last),
      .Input(act), .Weight(wgt), .ToRight(to_right[1]), .ToRightValid(trv[1]),
      .ToRightLast(trl[1]), .ToDown(to_down[1]), .PsumIn(psum_in[15:0]), .PsumInValid(psum_in_valid),
      .PsumInReady(pir[1]), .PsumOut(po1), .PsumOutValid(pov[1]), .PsumOutReady(out_ready),
      .Overrun(ovr[1]));

   os_mac_pe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)) u2 (
      .CLK(clk), .SYNC_RST(sync_rst), .EN(en), .InValid(in_valid), .InLast(in_last),
      .Input(act), .Weight(wgt), .ToRight(to_right[2]), .ToRightValid(trv[2]),
      .ToRightLast(trl[2]), .ToDown(to_down[2]), .PsumIn(psum_in[15:0]), .PsumInValid(psum_in_valid),
      .PsumInReady(pir[2]), .PsumOut(po2), .PsumOutValid(pov[2]), .PsumOutReady(out_ready),
      .Overrun(ovr[2]));

   always_comb begin
      po_w[0] = po0;
      po_w[1] = {8'd0, po1};
      po_w[2] = {8'd0, po2};
   end

   task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
      end
   endtask

   // Reference: tile result from plain integer arithmetic, clamped or wrapped each step.
   function automatic logic [23:0] ref_res(input int k, input int w, input bit sgn, input bit sat);
      longint s, p, lo, hi, m;
      m = longint'(1) << w;
      lo = sgn ? -(m / 2) : 0;
      hi = sgn ? (m / 2) - 1 : m - 1;
      s = 0;
      for (int i = 0; i < k; i++) begin
         p = sgn ? longint'($signed(ta[i])) * longint'($signed(tb[i]))
                 : longint'(ta[i]) * longint'(tb[i]);
         s = s + p;
         if (sat) begin
            if (s > hi) s = hi;
            else if (s < lo) s = lo;
         end else begin
            s = (s - lo) % m;
            if (s < 0) s = s + m;
            s = s + lo;
         end
      end
      return 24'(s & (m - 1));
   endfunction

   task automatic push_expected(input int k);
      exq[0].push_back(ref_res(k, 24, 1'b0, 1'b1));
      exq[1].push_back(ref_res(k, 16, 1'b1, 1'b1));
      exq[2].push_back(ref_res(k, 16, 1'b1, 1'b0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Drives ta/tb[0..k-1] back to back; InLast on the final pair when do_last.
   task automatic run_tile(input int k, input bit do_last, input bit push);
      if (push) push_expected(k);
      for (int i = 0; i < k; i++) begin
         en = 1'b1; in_valid = 1'b1;
         act = ta[i]; wgt = tb[i];
         in_last = do_last && (i == k - 1);
         tick();
      end
   endtask

   task automatic drain_wait();
      for (int c = 0; c < 40; c++) begin
         if (exq[0].size() == 0 && exq[1].size() == 0 && exq[2].size() == 0) break;
         tick();
      end
      tick();
      tick();
   endtask

   task automatic check_overrun(input logic exp_v);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("overrun[%0d]", i), 64'(ovr[i]), 64'(exp_v));
   endtask

   // Forwarding expectation: operands captured whenever EN is high.
   always @(posedge clk) begin
      if (sync_rst) begin
         fwd_exp   = 18'd0;
         fwd_known = 1'b1;
      end else if (en) begin
         fwd_exp = {act, wgt, in_valid, in_last};
      end
   end

   always @(negedge clk) begin
      if (fwd_known) begin
         for (int i = 0; i < 3; i++)
            check($sformatf("forward[%0d]", i), 64'({to_right[i], to_down[i], trv[i], trl[i]}), 64'(fwd_exp));
      end
   end

   // Scoreboard monitor: pops on each completed drain transfer, checks stall stability.
   always @(negedge clk) begin
      if (sync_rst) begin
         for (int j = 0; j < 3; j++) hold_v[j] = 1'b0;
      end else begin
         for (int j = 0; j < 3; j++) begin
            if (hold_v[j]) begin
               check($sformatf("hold_valid[%0d]", j), 64'(pov[j]), 64'd1);
               check($sformatf("hold_data[%0d]", j), 64'(po_w[j]), 64'(hold_d[j]));
            end
            if (pov[j] && out_ready) begin
               if (exq[j].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_out[%0d]: got %0h expected no output", j, po_w[j]);
               end else begin
                  check($sformatf("psum_out[%0d]", j), 64'(po_w[j]), 64'(exq[j].pop_front()));
               end
            end
            hold_v[j] = pov[j] && !out_ready;
            hold_d[j] = po_w[j];
         end
      end
   end

   initial begin
      int k_target, cnt, tiles, cyc;
      bit got;
      sync_rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      act = 8'd0; wgt = 8'd0; out_ready = 1'b1; psum_in = 24'd0; psum_in_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_valid[%0d]", i), 64'(pov[i]), 64'd0);
         check($sformatf("rst_out_data[%0d]", i), 64'(po_w[i]), 64'd0);
         check($sformatf("rst_overrun[%0d]", i), 64'(ovr[i]), 64'd0);
      end
      tick();
      sync_rst = 1'b0;

      // Unsigned K=4 tile: 15+14+100+1 = 130, visible one edge after the InLast edge.
      ta[0] = 8'd3;  tb[0] = 8'd5;  ta[1] = 8'd2; tb[1] = 8'd7;
      ta[2] = 8'd10; tb[2] = 8'd10; ta[3] = 8'd1; tb[3] = 8'd1;
      run_tile(4, 1'b1, 1'b1);
      idle();
      @(negedge clk);
      check("k4_not_yet_valid", 64'(pov[0]), 64'd0);
      tick();
      @(negedge clk);
      check("k4_valid", 64'(pov[0]), 64'd1);
      check("k4_value", 64'(po0), 64'd130);
      tick();
      @(negedge clk);
      check("k4_valid_one_cycle", 64'(pov[0]), 64'd0);
      drain_wait();

      // (-128,-128) x3: unsigned 49152, signed saturating 32767, signed wrapping 0xC000.
      for (int i = 0; i < 3; i++) begin ta[i] = 8'h80; tb[i] = 8'h80; end
      run_tile(3, 1'b1, 1'b1);
      idle();
      tick();
      @(negedge clk);
      check("neg_unsigned", 64'(po0), 64'd49152);
      check("neg_sat", 64'(po1), 64'h7FFF);
      check("neg_wrap", 64'(po2), 64'hC000);
      drain_wait();

      // Back-to-back tiles with no bubble: 2 then 16.
      ta[0] = 8'd1; tb[0] = 8'd1; ta[1] = 8'd1; tb[1] = 8'd1;
      run_tile(2, 1'b1, 1'b1);
      ta[0] = 8'd4; tb[0] = 8'd4;
      run_tile(1, 1'b1, 1'b1);
      idle();
      drain_wait();
      check_overrun(1'b0);
      tick();

      // Randomised tiles with gaps and EN stalls; PsumOutReady held high.
      k_target = $urandom_range(1, 6); cnt = 0; tiles = 0; cyc = 0;
      while (tiles < 60 && cyc < 5000) begin
         en       = ($urandom_range(0, 9) != 0);
         in_valid = ($urandom_range(0, 4) != 0);
         act      = 8'($urandom);
         wgt      = 8'($urandom);
         in_last  = in_valid ? (cnt == k_target - 1) : 1'($urandom_range(0, 1));
         if (en && in_valid) begin
            ta[cnt] = act; tb[cnt] = wgt;
            if (cnt == k_target - 1) begin
               push_expected(k_target);
               tiles++;
               cnt = 0;
               k_target = $urandom_range(1, 6);
            end else begin
               cnt++;
            end
         end
         tick();
         cyc++;
      end
      idle();
      drain_wait();
      check_overrun(1'b0);
      tick();

      // Local result pending while stalled with upstream data offered.
      out_ready = 1'b0;
      ta[0] = 8'd2; tb[0] = 8'd3;
      run_tile(1, 1'b1, 1'b1);
      ta[0] = 8'd4; tb[0] = 8'd5;
      run_tile(1, 1'b1, 1'b1);
      idle();
      psum_in = 24'h001234; psum_in_valid = 1'b1;
      exq[0].push_back(24'h001234);
      exq[1].push_back(24'h001234);
      exq[2].push_back(24'h001234);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) check($sformatf("psum_in_ready_blocked[%0d]", i), 64'(pir[i]), 64'd0);
         check("stalled_local", 64'(po0), 64'd6);
         tick();
      end
      out_ready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (pir[0] && pir[1] && pir[2]) got = 1'b1;
         tick();
      end
      psum_in_valid = 1'b0;
      check("psum_in_accepted", 64'(got), 64'd1);
      drain_wait();

      // Three tiles while stalled: first reaches the output, second is overwritten by third.
      out_ready = 1'b0;
      ta[0] = 8'd1; tb[0] = 8'd2;
      run_tile(1, 1'b1, 1'b1);
      ta[0] = 8'd3; tb[0] = 8'd3;
      run_tile(1, 1'b1, 1'b0);
      ta[0] = 8'd5; tb[0] = 8'd1;
      run_tile(1, 1'b1, 1'b1);
      idle();
      check_overrun(1'b1);
      check("overrun_out_head", 64'(po0), 64'd2);
      tick();
      out_ready = 1'b1;
      drain_wait();
      check_overrun(1'b1);
      tick();

      // Reset mid-tile, garbage inputs during reset, then a clean 1-pair tile.
      ta[0] = 8'd9; tb[0] = 8'd9; ta[1] = 8'd9; tb[1] = 8'd9;
      run_tile(2, 1'b0, 1'b0);
      sync_rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_last = 1'b1;
      act = 8'hFF; wgt = 8'hFF; psum_in_valid = 1'b1;
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrst_out_valid[%0d]", i), 64'(pov[i]), 64'd0);
         check($sformatf("midrst_out_data[%0d]", i), 64'(po_w[i]), 64'd0);
         check($sformatf("midrst_in_ready[%0d]", i), 64'(pir[i]), 64'd1);
      end
      tick();
      sync_rst = 1'b0; psum_in_valid = 1'b0;
      idle();
      check_overrun(1'b0);
      tick();
      ta[0] = 8'd6; tb[0] = 8'd7;
      run_tile(1, 1'b1, 1'b1);
      idle();
      tick();
      @(negedge clk);
      check("after_reset_42", 64'(po0), 64'd42);
      drain_wait();

      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("queue_empty[%0d]", i), 64'(exq[i].size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
